apb_slave_mem: RTL
==================

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, ACCESS-phase wait states inserted before PREADY (0..15).
REQ-002 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers; power of two, 2..256.
REQ-003 SHALL have input HCLK, 1 bit, the only clock; all state updates on its rising edge.
REQ-004 SHALL have input HRESETn, 1 bit, reset: asynchronous, active-low.
REQ-005 SHALL have input PSEL, 1 bit, slave select (one bit of the bridge's PSEL bus).
REQ-006 SHALL have input PENABLE, 1 bit, APB access-phase strobe.
REQ-007 SHALL have input PWRITE, 1 bit, 1 = write, 0 = read.
REQ-008 SHALL have input PADDR, 32 bits, byte address; word index is PADDR[log2(NUM_REGS)+1:2].
REQ-009 SHALL have input PWDATA, 32 bits, write data.
REQ-010 SHALL have output PRDATA, 32 bits, registered read data.
REQ-011 SHALL have output PREADY, 1 bit, transfer-complete indication.
REQ-012 SHALL have output PSLVERR, 1 bit, transfer error, meaningful only while PREADY=1.

Function
REQ-013 SHALL implement FSM IDLE/SETUP/ACCESS: IDLE->SETUP on PSEL=1 & PENABLE=0; SETUP->ACCESS unconditionally.
REQ-014 SHALL leave ACCESS on the PREADY=1 edge: to SETUP if PSEL=1 & PENABLE=0 that cycle, else to IDLE.
REQ-015 SHALL, in IDLE, ignore PENABLE=1 arriving without a prior SETUP: no state change, no write.
REQ-016 SHALL latch PADDR index, PWRITE and PWDATA at the SETUP->ACCESS edge; changes during ACCESS are ignored.
REQ-017 SHALL load a 4-bit wait counter with WAIT_CYCLES at the SETUP->ACCESS edge and decrement it each ACCESS cycle while nonzero.
REQ-018 SHALL drive PREADY combinationally = (state==ACCESS) & (counter==0); 0 in IDLE and SETUP.
REQ-019 SHALL, with WAIT_CYCLES=0, assert PREADY in the first ACCESS cycle (2-cycle transfer); with N, in ACCESS cycle N+1.
REQ-020 SHALL commit a write to the latched register at the rising edge where state==ACCESS & PREADY=1 & latched PWRITE=1 & no error.
REQ-021 SHALL load PRDATA from the register at the PADDR index at the SETUP->ACCESS edge for reads and hold it until the next read latch; writes leave PRDATA unchanged.
REQ-022 SHALL return the newly written value on a read issued back-to-back (SETUP directly after the write's ACCESS).
REQ-023 SHALL abort to IDLE if PSEL falls during ACCESS before PREADY: no write, PRDATA unchanged.
REQ-024 SHALL discard PADDR bits above the index: addresses wrap modulo NUM_REGS*4.

Reset
REQ-025 SHALL, on HRESETn low, immediately force state IDLE, counter 0, all registers 0, PRDATA 0, PREADY 0, PSLVERR 0.
REQ-026 SHALL drop an in-flight transfer on reset mid-ACCESS with no write, and accept a new SETUP on the first edge after release.

Configuration
REQ-027 SHALL honour macro APB_SLVERR_EN: when defined, PSLVERR = PREADY & (latched PADDR[1:0] != 0), and errored writes are suppressed and errored reads set PRDATA to 32'h0.
REQ-028 SHALL, without APB_SLVERR_EN, tie PSLVERR to 0 and ignore PADDR[1:0].

Structure
REQ-029 SHALL take state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the wait-counter width from shared package apb_pkg.
REQ-030 SHALL place FSM plus wait counter in sub-module apb_slave_fsm; register array and data path remain in apb_slave_mem.

Verification
REQ-031 SHALL verify write-then-read: write 32'hDEAD_BEEF to 0x08, read 0x08 -> PRDATA=32'hDEAD_BEEF, PREADY in ACCESS cycle 2 (WAIT_CYCLES=1).
REQ-032 SHALL verify WAIT_CYCLES=0 and =3: PREADY first high in ACCESS cycles 1 and 4 respectively.
REQ-033 SHALL verify back-to-back write 0x04=5 then read 0x04 with no IDLE -> PRDATA=5.
REQ-034 SHALL verify wrap: write 32'd31 to 0x40 (NUM_REGS=16), read 0x00 -> 32'd31.
REQ-035 SHALL verify HRESETn low mid-ACCESS of write 0x0C=7: 0x0C reads 0, all outputs 0 during reset.
REQ-036 SHALL verify, with APB_SLVERR_EN, write to 0x0A -> PSLVERR=1 with PREADY and the register unchanged; without it, PSLVERR=0 and 0x08 is written.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared encodings for the APB slave memory: FSM state codes and wait-counter width.
package apb_pkg;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETUP  = 2'b01;
    localparam logic [1:0] ST_ACCESS = 2'b10;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle; signal names follow the AMBA APB naming.
interface apb_slave_mem_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_slave_fsm.sv
// Transfer sequencer for the APB slave: IDLE/SETUP/ACCESS plus the wait-state down-counter.
//
// state  | meaning
// IDLE   | no transfer; waits for PSEL=1 with PENABLE=0
// SETUP  | address phase seen; next edge latches the request and loads the wait count
// ACCESS | counting down wait states; PREADY once the count reaches zero
module apb_slave_fsm
    import apb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       psel,
    input  logic       penable,
    output logic [1:0] state,
    output logic       pready
);

    cnt_t       cnt;
    logic [1:0] state_nxt;

    assign pready = (state == ST_ACCESS) && (cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (psel && !penable) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                // A deselect before completion abandons the transfer.
                if (pready)     state_nxt = (psel && !penable) ? ST_SETUP : ST_IDLE;
                else if (!psel) state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_SETUP)
                cnt <= cnt_t'(WAIT_CYCLES);
            else if (state == ST_ACCESS && cnt != '0)
                cnt <= cnt - cnt_t'(1);
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB register-file slave: NUM_REGS x 32-bit words with WAIT_CYCLES wait states per access.
// Optional macro APB_SLVERR_EN flags unaligned (PADDR[1:0] != 0) accesses via PSLVERR.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int NUM_REGS    = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    apb_slave_mem_if.slave        bus
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [1:0]       state;
    logic             ready;
    logic [IDX_W-1:0] idx_in;
    logic [IDX_W-1:0] idx_q;
    logic             write_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic [31:0]      regs [NUM_REGS];
    logic             addr_err;
    logic             setup_err;
    logic             unused_addr;

    apb_slave_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .psel    (bus.PSEL),
        .penable (bus.PENABLE),
        .state   (state),
        .pready  (ready)
    );

    // Upper address bits are dropped so the register file aliases every NUM_REGS*4 bytes.
    assign idx_in      = bus.PADDR[IDX_W+1:2];
    assign unused_addr = ^bus.PADDR;

`ifdef APB_SLVERR_EN
    logic [1:0] lo_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            lo_q <= 2'b00;
        else if (state == ST_SETUP)
            lo_q <= bus.PADDR[1:0];
    end

    assign addr_err  = (lo_q != 2'b00);
    assign setup_err = (bus.PADDR[1:0] != 2'b00);
`else
    assign addr_err  = 1'b0;
    assign setup_err = 1'b0;
`endif

    assign bus.PREADY  = ready;
    assign bus.PSLVERR = ready & addr_err;
    assign bus.PRDATA  = rdata_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (state == ST_SETUP) begin
            idx_q   <= idx_in;
            write_q <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
            if (!bus.PWRITE)
                rdata_q <= setup_err ? 32'h0 : regs[idx_in];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (ready && write_q && !addr_err) begin
            regs[idx_q] <= wdata_q;
        end
    end

endmodule
